// File: rtl/reorder_buffer_if.sv
// -----------------------------------------------------------------------------
// reorder_buffer_if
//   Groups the dispatch, writeback, operand-query and commit/rollback signals
//   of the reorder buffer into one bundle.
//
//   slave  : view taken by the reorder buffer itself
//   master : view taken by the surrounding pipeline (dispatcher, CDB,
//            reservation stations, register file, fetch)
//
//   Signal groups
//     alloc_*    : dispatcher allocation request and next rename tag, full flag
//     wb_*       : execution result broadcast, with mispredict / redirect info
//     q1_*, q2_* : operand forwarding queries
//     commit_*   : in-order retire pulse with rd / value / tag / pc
//     rollback_* : pipeline flush pulse and fetch restart PC
// -----------------------------------------------------------------------------
interface reorder_buffer_if #(
    parameter int ROB_ADDR_WIDTH = 4
);
    localparam int TAG_WIDTH = ROB_ADDR_WIDTH + 1;

    // allocation
    logic                 alloc_valid_in;
    logic [4:0]           alloc_rd_in;
    logic [31:0]          alloc_pc_in;
    logic [TAG_WIDTH-1:0] alloc_tag_out;
    logic                 full_out;

    // writeback
    logic                 wb_valid_in;
    logic [TAG_WIDTH-1:0] wb_tag_in;
    logic [31:0]          wb_value_in;
    logic                 wb_mispredict_in;
    logic [31:0]          wb_redirect_pc_in;

    // operand queries
    logic [TAG_WIDTH-1:0] q1_tag_in;
    logic                 q1_ready_out;
    logic [31:0]          q1_value_out;
    logic [TAG_WIDTH-1:0] q2_tag_in;
    logic                 q2_ready_out;
    logic [31:0]          q2_value_out;

    // commit / rollback
    logic                 commit_out;
    logic [4:0]           commit_rd_out;
    logic [31:0]          commit_value_out;
    logic [TAG_WIDTH-1:0] commit_tag_out;
    logic [31:0]          commit_pc_out;
    logic                 rollback_out;
    logic [31:0]          rollback_pc_out;

    modport slave (
        input  alloc_valid_in, alloc_rd_in, alloc_pc_in,
        output alloc_tag_out, full_out,
        input  wb_valid_in, wb_tag_in, wb_value_in, wb_mispredict_in, wb_redirect_pc_in,
        input  q1_tag_in, q2_tag_in,
        output q1_ready_out, q1_value_out, q2_ready_out, q2_value_out,
        output commit_out, commit_rd_out, commit_value_out, commit_tag_out, commit_pc_out,
        output rollback_out, rollback_pc_out
    );

    modport master (
        output alloc_valid_in, alloc_rd_in, alloc_pc_in,
        input  alloc_tag_out, full_out,
        output wb_valid_in, wb_tag_in, wb_value_in, wb_mispredict_in, wb_redirect_pc_in,
        output q1_tag_in, q2_tag_in,
        input  q1_ready_out, q1_value_out, q2_ready_out, q2_value_out,
        input  commit_out, commit_rd_out, commit_value_out, commit_tag_out, commit_pc_out,
        input  rollback_out, rollback_pc_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order retirement buffer for the Tomasulo core. Hands out rename
//   tags at allocation, captures execution results by tag, forwards in-flight
//   results to operand queries and retires the head entry in program order.
//   A retiring entry marked as mispredicted also raises a one-cycle rollback
//   that empties the whole buffer.
//
//   Tag 0 means "no dependency"; entry index i carries tag i+1.
//
//   Ports
//     clk_in : system clock, all state on the rising edge
//     rst_in : asynchronous, active-high reset
//     rdy_in : global enable; low freezes state, commit/rollback pulses forced 0
//     rob    : reorder_buffer_if.slave (alloc, writeback, query, commit, rollback)
//
//   Optional build macro
//     ROB_COMMIT_TRACE_EN : simulation-only retire counter with a printed line
//                           per commit and per rollback. Undefined by default.
// -----------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_ADDR_WIDTH = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    reorder_buffer_if.slave    rob
);
    localparam int ROB_SIZE  = 1 << ROB_ADDR_WIDTH;
    localparam int TAG_WIDTH = ROB_ADDR_WIDTH + 1;

    typedef logic [ROB_ADDR_WIDTH-1:0] idx_t;
    typedef logic [TAG_WIDTH-1:0]      tag_t;
    typedef logic [ROB_ADDR_WIDTH:0]   cnt_t;

    localparam cnt_t FULL_COUNT = cnt_t'(ROB_SIZE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    idx_t                head_reg;
    idx_t                tail_reg;
    cnt_t                count_reg;
    logic [ROB_SIZE-1:0] valid_reg;
    logic [ROB_SIZE-1:0] ready_reg;
    logic [ROB_SIZE-1:0] valid_next;
    logic [ROB_SIZE-1:0] ready_next;

    // Payload storage; only meaningful while the matching valid bit is set,
    // so it carries no reset.
    logic [4:0]          rd_mem       [ROB_SIZE];
    logic [31:0]         pc_mem       [ROB_SIZE];
    logic [31:0]         value_mem    [ROB_SIZE];
    logic                mispredict_mem [ROB_SIZE];
    logic [31:0]         redirect_mem [ROB_SIZE];

    // Registered outputs
    logic                commit_out_reg;
    logic [4:0]          commit_rd_reg;
    logic [31:0]         commit_value_reg;
    tag_t                commit_tag_reg;
    logic [31:0]         commit_pc_reg;
    logic                rollback_out_reg;
    logic [31:0]         rollback_pc_reg;

    // ------------------------------------------------------------------
    // Tag helpers
    // ------------------------------------------------------------------
    function automatic logic tag_in_range(input tag_t tag);
        return (tag != '0) && (tag <= tag_t'(ROB_SIZE));
    endfunction

    function automatic idx_t tag_to_idx(input tag_t tag);
        tag_t tag_m1;
        tag_m1 = tag - tag_t'(1);
        return tag_m1[ROB_ADDR_WIDTH-1:0];
    endfunction

    function automatic tag_t idx_to_tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle events
    // ------------------------------------------------------------------
    logic full_comb;
    logic active;
    logic head_ready;
    logic commit_fire;
    logic flush;
    logic alloc_fire;
    logic wb_fire;
    idx_t wb_idx;

    assign full_comb  = (count_reg == FULL_COUNT);
    assign wb_idx     = tag_to_idx(rob.wb_tag_in);
    assign head_ready = valid_reg[head_reg] && ready_reg[head_reg];

    // The cycle after a rollback the buffer is already empty and everything
    // upstream is being flushed, so no input is accepted.
    assign active      = rdy_in && !rollback_out_reg;
    assign commit_fire = active && (count_reg != '0) && head_ready;
    assign flush       = commit_fire && mispredict_mem[head_reg];
    // Full blocks allocation even when the head retires this same cycle.
    assign alloc_fire  = active && rob.alloc_valid_in && !full_comb;
    assign wb_fire     = active && rob.wb_valid_in && tag_in_range(rob.wb_tag_in)
                         && valid_reg[wb_idx];

    // ------------------------------------------------------------------
    // Per-entry valid / ready next-state
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < ROB_SIZE; gi++) begin : g_entry
            logic alloc_hit;
            logic wb_hit;
            logic commit_hit;

            assign alloc_hit  = alloc_fire  && (tail_reg == idx_t'(gi));
            assign wb_hit     = wb_fire     && (wb_idx   == idx_t'(gi));
            assign commit_hit = commit_fire && (head_reg == idx_t'(gi));

            assign valid_next[gi] = flush      ? 1'b0 :
                                    alloc_hit  ? 1'b1 :
                                    commit_hit ? 1'b0 : valid_reg[gi];
            assign ready_next[gi] = flush      ? 1'b0 :
                                    alloc_hit  ? 1'b0 :
                                    wb_hit     ? 1'b1 : ready_reg[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Operand forwarding queries
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_query
            tag_t        tag_c;
            idx_t        idx_c;
            logic        ready_c;
            logic [31:0] value_c;

            assign tag_c = (gi == 0) ? rob.q1_tag_in : rob.q2_tag_in;
            assign idx_c = tag_to_idx(tag_c);

            // A result on the broadcast bus this cycle wins over stored state,
            // so a consumer can pick it up in the same cycle it is produced.
            always_comb begin
                ready_c = 1'b0;
                value_c = 32'h0;
                if (tag_c != '0) begin
                    if (rob.wb_valid_in && (rob.wb_tag_in == tag_c)) begin
                        ready_c = 1'b1;
                        value_c = rob.wb_value_in;
                    end else if (tag_in_range(tag_c) && valid_reg[idx_c]
                                 && ready_reg[idx_c]) begin
                        ready_c = 1'b1;
                        value_c = value_mem[idx_c];
                    end
                end
            end
        end
    endgenerate

    assign rob.q1_ready_out = g_query[0].ready_c;
    assign rob.q1_value_out = g_query[0].value_c;
    assign rob.q2_ready_out = g_query[1].ready_c;
    assign rob.q2_value_out = g_query[1].value_c;

    // ------------------------------------------------------------------
    // Payload writes
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (alloc_fire) begin
            rd_mem[tail_reg] <= rob.alloc_rd_in;
            pc_mem[tail_reg] <= rob.alloc_pc_in;
        end
        if (wb_fire) begin
            value_mem[wb_idx]      <= rob.wb_value_in;
            mispredict_mem[wb_idx] <= rob.wb_mispredict_in;
            redirect_mem[wb_idx]   <= rob.wb_redirect_pc_in;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            valid_reg        <= '0;
            ready_reg        <= '0;
            commit_out_reg   <= 1'b0;
            commit_rd_reg    <= '0;
            commit_value_reg <= '0;
            commit_tag_reg   <= '0;
            commit_pc_reg    <= '0;
            rollback_out_reg <= 1'b0;
            rollback_pc_reg  <= '0;
        end else begin
            valid_reg        <= valid_next;
            ready_reg        <= ready_next;
            commit_out_reg   <= commit_fire;
            rollback_out_reg <= flush;

            // Data outputs hold their last retired values between pulses.
            if (commit_fire) begin
                commit_rd_reg    <= rd_mem[head_reg];
                commit_value_reg <= value_mem[head_reg];
                commit_tag_reg   <= idx_to_tag(head_reg);
                commit_pc_reg    <= pc_mem[head_reg];
            end

            if (flush) begin
                // The mispredicted entry still retires; everything younger,
                // including a same-cycle allocation, is discarded.
                rollback_pc_reg <= redirect_mem[head_reg];
                head_reg        <= '0;
                tail_reg        <= '0;
                count_reg       <= '0;
            end else begin
                if (commit_fire) begin
                    head_reg <= head_reg + idx_t'(1);
                end
                if (alloc_fire) begin
                    tail_reg <= tail_reg + idx_t'(1);
                end
                if (alloc_fire && !commit_fire) begin
                    count_reg <= count_reg + cnt_t'(1);
                end else if (!alloc_fire && commit_fire) begin
                    count_reg <= count_reg - cnt_t'(1);
                end
            end
        end
    end

    assign rob.alloc_tag_out    = idx_to_tag(tail_reg);
    assign rob.full_out         = full_comb;
    assign rob.commit_out       = commit_out_reg;
    assign rob.commit_rd_out    = commit_rd_reg;
    assign rob.commit_value_out = commit_value_reg;
    assign rob.commit_tag_out   = commit_tag_reg;
    assign rob.commit_pc_out    = commit_pc_reg;
    assign rob.rollback_out     = rollback_out_reg;
    assign rob.rollback_pc_out  = rollback_pc_reg;

`ifdef ROB_COMMIT_TRACE_EN
    // ------------------------------------------------------------------
    // Retire trace (simulation only)
    // ------------------------------------------------------------------
    logic [31:0] retire_count_reg;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            retire_count_reg <= '0;
        end else begin
            if (commit_out_reg) begin
                retire_count_reg <= retire_count_reg + 32'd1;
                $display("ROB retire #%0d pc=%08h rd=%0d value=%08h",
                         retire_count_reg + 32'd1, commit_pc_reg,
                         commit_rd_reg, commit_value_reg);
            end
            if (rollback_out_reg) begin
                $display("ROB rollback pc=%08h", rollback_pc_reg);
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    reorder_buffer_if #(.ROB_ADDR_WIDTH(4)) rob_bus ();

    reorder_buffer #(.ROB_ADDR_WIDTH(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rob_bus)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;   logic [4:0] ard;  logic [31:0] apc;
        logic        wv;   logic [4:0] wtag; logic [31:0] wval;
        logic        wmis; logic [31:0] wred;
        logic [4:0]  q1;   logic [4:0] q2;
        logic [4:0]  atag; logic full;
        logic        q1r;  logic [31:0] q1v; logic q2r; logic [31:0] q2v;
        logic        com;  logic [4:0] crd;  logic [31:0] cval;
        logic [4:0]  ctag; logic [31:0] cpc;
        logic        rb;   logic [31:0] rbpc;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t mk(
        input int av, input int ard, input int apc,
        input int wv, input int wtag, input int wval, input int wmis, input int wred,
        input int q1, input int q2,
        input int atag, input int full, input int q1r, input int q1v, input int q2r, input int q2v,
        input int com, input int crd, input int cval, input int ctag, input int cpc,
        input int rb, input int rbpc);
        vec_t v;
        v.av = 1'(av);     v.ard = 5'(ard);   v.apc = 32'(apc);
        v.wv = 1'(wv);     v.wtag = 5'(wtag); v.wval = 32'(wval);
        v.wmis = 1'(wmis); v.wred = 32'(wred);
        v.q1 = 5'(q1);     v.q2 = 5'(q2);
        v.atag = 5'(atag); v.full = 1'(full);
        v.q1r = 1'(q1r);   v.q1v = 32'(q1v);  v.q2r = 1'(q2r); v.q2v = 32'(q2v);
        v.com = 1'(com);   v.crd = 5'(crd);   v.cval = 32'(cval);
        v.ctag = 5'(ctag); v.cpc = 32'(cpc);
        v.rb = 1'(rb);     v.rbpc = 32'(rbpc);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] apc,
                         input logic wv, input logic [4:0] wtag, input logic [31:0] wval,
                         input logic wmis, input logic [31:0] wred,
                         input logic [4:0] q1, input logic [4:0] q2);
        rob_bus.alloc_valid_in    = av;
        rob_bus.alloc_rd_in       = ard;
        rob_bus.alloc_pc_in       = apc;
        rob_bus.wb_valid_in       = wv;
        rob_bus.wb_tag_in         = wtag;
        rob_bus.wb_value_in       = wval;
        rob_bus.wb_mispredict_in  = wmis;
        rob_bus.wb_redirect_pc_in = wred;
        rob_bus.q1_tag_in         = q1;
        rob_bus.q2_tag_in         = q2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
    endtask

    initial begin
        // Sequence A: single round trip, out-of-order writeback, bypass,
        // ignored writebacks, mispredict rollback.
        vecs[0]  = mk(1,5,'h0,   0,0,0,0,0,           0,0, 1,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[1]  = mk(0,0,0,     1,1,'h1234,0,0,      1,0, 2,0,1,'h1234,0,0,     0,0,0,0,0,            0,0);
        vecs[2]  = mk(0,0,0,     0,0,0,0,0,           1,0, 2,0,1,'h1234,0,0,     1,5,'h1234,1,'h0,     0,0);
        vecs[3]  = mk(0,0,0,     0,0,0,0,0,           1,0, 2,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[4]  = mk(1,1,'h10,  0,0,0,0,0,           0,0, 2,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[5]  = mk(1,2,'h14,  0,0,0,0,0,           0,0, 3,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[6]  = mk(1,3,'h18,  0,0,0,0,0,           0,0, 4,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[7]  = mk(0,0,0,     1,4,'h44,0,0,        4,2, 5,0,1,'h44,0,0,       0,0,0,0,0,            0,0);
        vecs[8]  = mk(0,0,0,     1,2,'h22,0,0,        4,0, 5,0,1,'h44,0,0,       0,0,0,0,0,            0,0);
        vecs[9]  = mk(0,0,0,     1,3,'h33,0,0,        2,3, 5,0,1,'h22,1,'h33,    1,1,'h22,2,'h10,      0,0);
        vecs[10] = mk(0,0,0,     0,0,0,0,0,           3,0, 5,0,1,'h33,0,0,       1,2,'h33,3,'h14,      0,0);
        vecs[11] = mk(0,0,0,     0,0,0,0,0,           0,0, 5,0,0,0,0,0,          1,3,'h44,4,'h18,      0,0);
        vecs[12] = mk(0,0,0,     0,0,0,0,0,           0,0, 5,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[13] = mk(0,0,0,     1,2,'hBEEF,0,0,      2,0, 5,0,1,'hBEEF,0,0,     0,0,0,0,0,            0,0);
        vecs[14] = mk(0,0,0,     0,0,0,0,0,           2,0, 5,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[15] = mk(1,7,'h20,  0,0,0,0,0,           0,0, 5,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[16] = mk(1,8,'h24,  0,0,0,0,0,           0,0, 6,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[17] = mk(1,9,'h28,  0,0,0,0,0,           0,0, 7,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[18] = mk(0,0,0,     1,5,'h55,1,'h100,    0,0, 8,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[19] = mk(1,10,'h2c, 0,0,0,0,0,           0,0, 8,0,0,0,0,0,          1,7,'h55,5,'h20,      1,'h100);
        vecs[20] = mk(1,11,'h40, 1,6,'h66,0,0,        0,0, 1,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[21] = mk(0,0,0,     0,0,0,0,0,           6,0, 1,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[22] = mk(0,0,0,     1,2,'h77,0,0,        0,0, 1,0,0,0,0,0,          0,0,0,0,0,            0,0);
        vecs[23] = mk(0,0,0,     0,0,0,0,0,           0,0, 1,0,0,0,0,0,          0,0,0,0,0,            0,0);

        rst_in = 1'b1;
        rdy_in = 1'b1;
        idle();

        // Reset state
        #2;
        check("reset alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd1);
        check("reset full", 32'(rob_bus.full_out), 32'd0);
        check("reset commit", 32'(rob_bus.commit_out), 32'd0);
        check("reset commit_value", rob_bus.commit_value_out, 32'h0);
        check("reset rollback", 32'(rob_bus.rollback_out), 32'd0);
        $display("reset: alloc_tag=%0d full=%0b", rob_bus.alloc_tag_out, rob_bus.full_out);

        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 24; i++) begin
            @(negedge clk_in);
            drive(vecs[i].av, vecs[i].ard, vecs[i].apc, vecs[i].wv, vecs[i].wtag,
                  vecs[i].wval, vecs[i].wmis, vecs[i].wred, vecs[i].q1, vecs[i].q2);
            #1;
            check($sformatf("v%0d alloc_tag", i), 32'(rob_bus.alloc_tag_out), 32'(vecs[i].atag));
            check($sformatf("v%0d full", i), 32'(rob_bus.full_out), 32'(vecs[i].full));
            check($sformatf("v%0d q1_ready", i), 32'(rob_bus.q1_ready_out), 32'(vecs[i].q1r));
            check($sformatf("v%0d q1_value", i), rob_bus.q1_value_out, vecs[i].q1v);
            check($sformatf("v%0d q2_ready", i), 32'(rob_bus.q2_ready_out), 32'(vecs[i].q2r));
            check($sformatf("v%0d q2_value", i), rob_bus.q2_value_out, vecs[i].q2v);
            @(posedge clk_in);
            #1;
            check($sformatf("v%0d commit", i), 32'(rob_bus.commit_out), 32'(vecs[i].com));
            check($sformatf("v%0d rollback", i), 32'(rob_bus.rollback_out), 32'(vecs[i].rb));
            if (vecs[i].com) begin
                check($sformatf("v%0d commit_rd", i), 32'(rob_bus.commit_rd_out), 32'(vecs[i].crd));
                check($sformatf("v%0d commit_value", i), rob_bus.commit_value_out, vecs[i].cval);
                check($sformatf("v%0d commit_tag", i), 32'(rob_bus.commit_tag_out), 32'(vecs[i].ctag));
                check($sformatf("v%0d commit_pc", i), rob_bus.commit_pc_out, vecs[i].cpc);
            end
            if (vecs[i].rb) begin
                check($sformatf("v%0d rollback_pc", i), rob_bus.rollback_pc_out, vecs[i].rbpc);
            end
            $display("vec %0d: commit=%0b tag=%0d rollback=%0b alloc_tag=%0d",
                     i, rob_bus.commit_out, rob_bus.commit_tag_out,
                     rob_bus.rollback_out, rob_bus.alloc_tag_out);
        end

        // Sequence B: fill all 16 entries (buffer is empty, tail at index 0).
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_in);
            drive(1'b1, 5'(i + 1), 32'h1000 + 32'(i * 4), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
            #1;
            check($sformatf("fill%0d alloc_tag", i), 32'(rob_bus.alloc_tag_out), 32'(i + 1));
            @(posedge clk_in);
        end
        @(negedge clk_in);
        idle();
        #1;
        check("filled full", 32'(rob_bus.full_out), 32'd1);
        check("filled alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd1);
        $display("fill: full=%0b alloc_tag=%0d", rob_bus.full_out, rob_bus.alloc_tag_out);

        // 17th allocation is dropped
        @(negedge clk_in);
        drive(1'b1, 5'd30, 32'hDEAD, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        @(posedge clk_in);
        #1;
        check("alloc17 full", 32'(rob_bus.full_out), 32'd1);
        check("alloc17 alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd1);
        $display("alloc17: full=%0b alloc_tag=%0d", rob_bus.full_out, rob_bus.alloc_tag_out);

        // Writeback head, then allocate while it retires (still full -> dropped)
        @(negedge clk_in);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'hA1, 1'b0, 32'h0, 5'd0, 5'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        drive(1'b1, 5'd31, 32'hBAD, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd0, 5'd0);
        @(posedge clk_in);
        #1;
        check("wrap commit", 32'(rob_bus.commit_out), 32'd1);
        check("wrap commit_tag", 32'(rob_bus.commit_tag_out), 32'd1);
        check("wrap commit_value", rob_bus.commit_value_out, 32'hA1);
        check("wrap commit_pc", rob_bus.commit_pc_out, 32'h1000);
        check("wrap full dropped", 32'(rob_bus.full_out), 32'd0);
        check("wrap alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd1);
        $display("wrap commit: tag=%0d full=%0b alloc_tag=%0d",
                 rob_bus.commit_tag_out, rob_bus.full_out, rob_bus.alloc_tag_out);

        @(negedge clk_in);
        drive(1'b1, 5'd9, 32'h2000, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 5'd1, 5'd0);
        #1;
        check("wrap q1 fresh entry", 32'(rob_bus.q1_ready_out), 32'd0);
        @(posedge clk_in);
        #1;
        check("wrap realloc full", 32'(rob_bus.full_out), 32'd1);
        check("wrap realloc alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd2);
        $display("wrap alloc: full=%0b alloc_tag=%0d", rob_bus.full_out, rob_bus.alloc_tag_out);

        // Sequence C: rdy_in low freezes a ready head (tag 2, pc 0x1004, rd 2).
        @(negedge clk_in);
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'hB2, 1'b0, 32'h0, 5'd0, 5'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        idle();
        rob_bus.q1_tag_in = 5'd2;
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall%0d q1_ready", i), 32'(rob_bus.q1_ready_out), 32'd1);
            check($sformatf("stall%0d q1_value", i), rob_bus.q1_value_out, 32'hB2);
            @(posedge clk_in);
            #1;
            check($sformatf("stall%0d commit", i), 32'(rob_bus.commit_out), 32'd0);
            check($sformatf("stall%0d full", i), 32'(rob_bus.full_out), 32'd1);
            $display("stall %0d: commit=%0b full=%0b", i, rob_bus.commit_out, rob_bus.full_out);
            @(negedge clk_in);
        end
        rdy_in = 1'b1;
        @(posedge clk_in);
        #1;
        check("resume commit", 32'(rob_bus.commit_out), 32'd1);
        check("resume commit_tag", 32'(rob_bus.commit_tag_out), 32'd2);
        check("resume commit_rd", 32'(rob_bus.commit_rd_out), 32'd2);
        check("resume commit_value", rob_bus.commit_value_out, 32'hB2);
        check("resume commit_pc", rob_bus.commit_pc_out, 32'h1004);
        $display("resume: commit=%0b tag=%0d", rob_bus.commit_out, rob_bus.commit_tag_out);

        // Asynchronous reset in the middle of the commit cycle
        #1;
        rst_in = 1'b1;
        #1;
        check("async rst commit", 32'(rob_bus.commit_out), 32'd0);
        check("async rst commit_tag", 32'(rob_bus.commit_tag_out), 32'd0);
        check("async rst full", 32'(rob_bus.full_out), 32'd0);
        check("async rst alloc_tag", 32'(rob_bus.alloc_tag_out), 32'd1);
        check("async rst q1 flushed", 32'(rob_bus.q1_ready_out), 32'd0);
        $display("async reset: commit=%0b full=%0b alloc_tag=%0d",
                 rob_bus.commit_out, rob_bus.full_out, rob_bus.alloc_tag_out);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle();
        @(posedge clk_in);
        #1;
        check("post rst commit", 32'(rob_bus.commit_out), 32'd0);
        check("post rst full", 32'(rob_bus.full_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer for the Tomasulo core.
- Hands rename tags to the dispatcher and captures execution results by tag.
- Answers operand-forwarding queries for in-flight results.
- Retires the head entry in program order, driving the register-file commit interface (rd, value, tag) and the pipeline-wide rollback on branch mispredict.
- Tag value 0 is reserved as "no dependency"; entry index i carries tag i+1.

Parameters:
ROB_ADDR_WIDTH, 4, log2 of entry count; ROB_SIZE = 2**ROB_ADDR_WIDTH = 16
TAG_WIDTH, ROB_ADDR_WIDTH+1, rename tag width; 0 = none

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
rdy_in  input  1  global enable; low freezes all state
alloc_valid_in  input  1  dispatcher allocates one entry this cycle
alloc_rd_in  input  5  destination register (0 = none)
alloc_pc_in  input  32  instruction PC
alloc_tag_out  output  TAG_WIDTH  tag the next allocation receives (tail+1), combinational
full_out  output  1  count == ROB_SIZE, combinational
wb_valid_in  input  1  result broadcast valid
wb_tag_in  input  TAG_WIDTH  tag of result
wb_value_in  input  32  result value
wb_mispredict_in  input  1  entry is a mispredicted control transfer
wb_redirect_pc_in  input  32  correct next PC when mispredicted
q1_tag_in  input  TAG_WIDTH  operand-1 forwarding query
q1_ready_out  output  1  queried result available
q1_value_out  output  32  forwarded value (0 when not ready)
q2_tag_in  input  TAG_WIDTH  operand-2 query
q2_ready_out  output  1  as q1
q2_value_out  output  32  as q1
commit_out  output  1  one-cycle retire pulse
commit_rd_out  output  5  retired destination
commit_value_out  output  32  retired value
commit_tag_out  output  TAG_WIDTH  retired tag (register file clears mapping only if it matches)
commit_pc_out  output  32  retired PC
rollback_out  output  1  one-cycle flush pulse
rollback_pc_out  output  32  fetch restart PC

Behaviour:
- Reset (async, rst_in high): head = tail = count = 0; all entry valid/ready bits cleared; every registered output 0; alloc_tag_out = 1.
- Entry fields: valid, ready, rd, pc, value, mispredict, redirect_pc.
- Allocation:
  - On alloc_valid_in && !full_out && !rollback_out: entry[tail] gets valid=1, ready=0, rd/pc captured; tail wraps modulo ROB_SIZE.
  - When full, allocation is ignored, even if a commit happens the same cycle.
- Writeback:
  - On wb_valid_in with nonzero tag whose entry is valid: set ready=1 and store value, mispredict and redirect_pc.
  - Writeback to an invalid entry or to tag 0 is ignored.
- Query:
  - ready_out = 1 if the tag is nonzero and either the entry is valid and ready, or the same-cycle wb_valid_in matches the tag (bypass; wb_value_in forwarded).
  - Tag 0 gives ready_out = 0, value 0.
- Commit:
  - Each cycle, if count > 0 and entry[head] is ready, the next edge registers commit_out = 1 with that entry's rd/value/tag/pc, clears valid, and advances head (wraps).
  - At most one commit per cycle; latency is writeback edge -> earliest commit pulse one edge later.
  - Otherwise commit_out = 0; the data outputs hold their last values.
- Rollback:
  - If the committing entry has mispredict=1, that same edge also sets rollback_out = 1 and rollback_pc_out = redirect_pc, still commits the entry, and flushes all entries: head = tail = count = 0, all valid bits cleared.
  - During the rollback_out cycle, allocation and writeback inputs are ignored; no commit occurs.
- Count:
  - Allocation plus commit in the same cycle leaves count unchanged.
  - Count width is ROB_ADDR_WIDTH+1, never exceeding ROB_SIZE.
- rdy_in low:
  - No allocation, writeback, or commit takes effect.
  - commit_out and rollback_out are driven 0; all other state holds.
  - Combinational query and full outputs still track current state.
- rst_in asserted mid-operation discards all in-flight entries immediately.

Optional Feature:
- Macro ROB_COMMIT_TRACE_EN.
- Defined: a 32-bit internal retire counter increments on each commit_out pulse. Each commit prints via $display the counter, pc, rd, and value; each rollback prints rollback_pc. Simulation only, no port change.
- Undefined: no counter and no display statements; ports and behaviour are otherwise identical.

Test Plan:
- Reset then allocate pc=0x0 rd=5 -> alloc_tag_out goes 1 -> 2. wb tag 1 value 0x1234 -> next edge commit_out=1, rd=5, value=0x1234, tag=1, pc=0x0.
- Allocate tags 1,2,3; writeback in order 3,1,2 -> commits occur only in order 1,2,3 on three consecutive cycles.
- Allocate 16 entries without writeback -> full_out=1 and a 17th alloc is ignored (tail unchanged). Writeback tag 1 -> commit, full_out drops; next alloc receives tag 1 (wrap).
- Query q1_tag=2 in the same cycle as wb tag 2 value 0xBEEF -> q1_ready_out=1, q1_value_out=0xBEEF. Query tag 0 -> ready 0.
- Allocate tags 1,2,3; wb tag 1 with mispredict=1, redirect=0x100 -> commit pulse for tag 1 together with rollback_out=1, rollback_pc_out=0x100. Next cycle full_out=0 and alloc_tag_out=1. A later wb on tag 2 produces no commit.
- Hold rdy_in low with ready head entry for 3 cycles -> no commit_out. Raise rdy_in -> commit on the next edge. Assert rst_in mid-stream -> outputs 0 asynchronously.
